// File: rtl/ao486_dma_pkg.sv
// Shared types and helpers for the HPS sector DMA bridge.
// Holds the state encoding, the default burst size and the sector address helper.
package ao486_dma_pkg;

    localparam int DEF_BURST_WORDS = 128;

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        RD_REQ,
        RD_DATA,
        WR_BURST,
        DONE
    } dma_state_t;

    // Clears the dword index and byte offset, leaving the sector-aligned byte address.
    function automatic logic [31:0] sector_base(input logic [31:0] addr, input int idxw);
        return addr & (32'hFFFF_FFFF << (idxw + 2));
    endfunction

endpackage

// File: rtl/sector_ram.sv
// One-sector buffer: simple dual-port RAM with one write port and one registered read port.
// A read of the address being written in the same cycle returns the old contents.
module sector_ram #(
    parameter int WORDS = 128,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_sys,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hps_sector_dma.sv
// Bridges per-dword hps_io DMA traffic to the Avalon mem port in whole-sector bursts.
// Read misses fill the sector buffer in one burst; full sequential write sectors flush in one burst.
module hps_sector_dma
    import ao486_dma_pkg::*;
#(
    parameter int BURST_WORDS = DEF_BURST_WORDS
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dma_rd,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_dout,
    output logic [31:0] dma_din,
    output logic        ioctl_wait,
    input  logic        inv,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_burstcount,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid
);

    localparam int              IDXW     = $clog2(BURST_WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BURST_WORDS - 1);
    localparam logic [IDXW:0]   FULL_CNT = (IDXW + 1)'(BURST_WORDS);

    dma_state_t      state;
    logic [IDXW-1:0] idx, idx_q, beat;
    logic [IDXW-1:0] ram_waddr, ram_raddr;
    logic [31:0]     base, tag, ram_wdata, ram_rdata;
    logic [IDXW:0]   wr_cnt, wr_cnt_nxt;
    logic            rd_valid, inv_pend, ram_we, accept_op, rd_hit;

    assign idx            = dma_addr[IDXW+1:2];
    assign base           = sector_base(dma_addr, IDXW);
    assign accept_op      = (state == IDLE) && !ioctl_wait;
    assign rd_hit         = rd_valid && (tag == base);
    assign wr_cnt_nxt     = (idx == '0) ? (IDXW + 1)'(1) : wr_cnt + 1'b1;
    assign mem_burstcount = 8'(BURST_WORDS);
    assign mem_writedata  = ram_rdata;

    // The read port looks one beat ahead during a write burst so every accepted beat has data ready.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = idx;
        ram_wdata = dma_dout;
        if (!reset) begin
            if (accept_op && dma_wr && !dma_rd) begin
                ram_we = 1'b1;
            end else if (state == RD_DATA && mem_readdatavalid) begin
                ram_we    = 1'b1;
                ram_waddr = beat;
                ram_wdata = mem_readdata;
            end
        end
        ram_raddr = '0;
        case (state)
            IDLE:     if (dma_rd) ram_raddr = idx;
            WR_BURST: ram_raddr = mem_waitrequest ? beat : beat + 1'b1;
            default:  ram_raddr = '0;
        endcase
    end

    sector_ram #(
        .WORDS (BURST_WORDS)
    ) u_buf (
        .clk_sys (clk_sys),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr   (ram_raddr),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            ioctl_wait  <= 1'b0;
            dma_din     <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            rd_valid    <= 1'b0;
            inv_pend    <= 1'b0;
            wr_cnt      <= '0;
            tag         <= '0;
            beat        <= '0;
            idx_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ioctl_wait) begin
                        ioctl_wait <= 1'b0;
                    end else if (dma_rd) begin
                        idx_q      <= idx;
                        ioctl_wait <= 1'b1;
                        if (rd_hit) begin
                            state <= HIT;
                        end else begin
                            rd_valid    <= 1'b0;
                            inv_pend    <= 1'b0;
                            wr_cnt      <= '0;
                            mem_address <= base;
                            mem_read    <= 1'b1;
                            beat        <= '0;
                            state       <= RD_REQ;
                        end
                    end else if (dma_wr) begin
                        rd_valid   <= 1'b0;
                        ioctl_wait <= 1'b1;
                        if (idx == LAST_IDX) begin
                            wr_cnt <= '0;
                            if (wr_cnt_nxt == FULL_CNT) begin
                                mem_address <= base;
                                mem_write   <= 1'b1;
                                beat        <= '0;
                                state       <= WR_BURST;
                            end
                        end else begin
                            wr_cnt <= wr_cnt_nxt;
                        end
                    end
                end
                HIT: begin
                    dma_din    <= ram_rdata;
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                RD_REQ: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= RD_DATA;
                    end
                end
                // The requested dword is taken straight off the beat stream, which also covers
                // the case where it is the final beat and not yet readable from the buffer.
                RD_DATA: begin
                    if (mem_readdatavalid) begin
                        if (beat == idx_q) begin
                            dma_din <= mem_readdata;
                        end
                        beat <= beat + 1'b1;
                        if (beat == LAST_IDX) begin
                            tag      <= mem_address;
                            rd_valid <= !inv_pend;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                WR_BURST: begin
                    if (!mem_waitrequest) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_IDX) begin
                            mem_write  <= 1'b0;
                            ioctl_wait <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (inv) begin
                rd_valid <= 1'b0;
                inv_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hps_sector_dma.sv
// Directed bench for hps_sector_dma with a behavioural Avalon slave and a fill-pattern memory.
`timescale 1ns/1ps
module tb_hps_sector_dma;

    localparam int BW = 128;

    logic        clk_sys = 1'b0;
    logic        reset, dma_rd, dma_wr, inv;
    logic [31:0] dma_addr, dma_dout, dma_din;
    logic        ioctl_wait;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest, mem_readdatavalid;
    logic [7:0]  mem_burstcount;

    int checks = 0;
    int passed = 0;

    int          rd_bursts = 0;
    int          wr_bursts = 0;
    int          wr_beats_total = 0;
    int          wr_addr_err = 0;
    int          rd_left = 0;
    int          rd_sent = 0;
    int          wr_idx = 0;
    bit          stall_en = 1'b0;
    logic [31:0] rd_base = '0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] wr_capt [BW];
    logic [31:0] wr_store [logic [31:0]];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        int          exp_wait;
    } rd_vec_t;

    always #5 clk_sys = ~clk_sys;

    hps_sector_dma #(
        .BURST_WORDS (BW)
    ) dut (
        .clk_sys           (clk_sys),
        .reset             (reset),
        .dma_rd            (dma_rd),
        .dma_wr            (dma_wr),
        .dma_addr          (dma_addr),
        .dma_dout          (dma_dout),
        .dma_din           (dma_din),
        .ioctl_wait        (ioctl_wait),
        .inv               (inv),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_burstcount    (mem_burstcount),
        .mem_writedata     (mem_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (wr_store.exists(a)) return wr_store[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] wdat(input int i);
        return 32'hC0DE_0000 + 32'(i * 37);
    endfunction

    // Avalon slave: decisions are made on the falling edge and take effect at the next rising edge.
    initial begin
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        forever begin
            @(negedge clk_sys);
            mem_waitrequest = stall_en && ($urandom_range(0, 2) == 0);
            if (rd_left > 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = model_rd(rd_base + 32'(4 * rd_sent));
                rd_sent++;
                rd_left--;
            end else begin
                mem_readdatavalid = 1'b0;
                mem_readdata      = '0;
            end
            if (mem_read && !mem_waitrequest) begin
                rd_bursts++;
                last_rd_addr = mem_address;
                rd_base      = mem_address;
                rd_sent      = 0;
                rd_left      = BW;
            end
            if (mem_write && !mem_waitrequest) begin
                if (wr_idx == 0) last_wr_addr = mem_address;
                else if (mem_address != last_wr_addr) wr_addr_err++;
                wr_capt[wr_idx] = mem_writedata;
                wr_store[mem_address + 32'(4 * wr_idx)] = mem_writedata;
                wr_beats_total++;
                wr_idx++;
                if (wr_idx == BW) begin
                    wr_idx = 0;
                    wr_bursts++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_idle(output int wc);
        wc = 0;
        while (ioctl_wait && wc < 2000) begin
            wc++;
            @(negedge clk_sys);
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rdata, output int wc);
        @(negedge clk_sys);
        dma_rd   = rd;
        dma_wr   = wr;
        dma_addr = addr;
        dma_dout = wdata;
        @(negedge clk_sys);
        dma_rd = 1'b0;
        dma_wr = 1'b0;
        wait_idle(wc);
        rdata = dma_din;
    endtask

    initial begin
        logic [31:0] d;
        int          wc, bad, rb0;
        rd_vec_t     vecs[6];

        reset = 1'b1; dma_rd = 1'b0; dma_wr = 1'b0; inv = 1'b0;
        dma_addr = '0; dma_dout = '0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check_output("reset ioctl_wait", ioctl_wait, 0);
        check_output("reset dma_din", dma_din, 0);
        check_output("reset mem_read", mem_read, 0);
        check_output("reset mem_write", mem_write, 0);
        check_output("reset mem_address", mem_address, 0);
        check_output("burstcount", mem_burstcount, 128);

        // Cold read miss fills the whole sector.
        apply_stimulus(1, 0, 32'h1000, 0, d, wc);
        check_output("miss data", d, init_word(32'h1000));
        check_output("miss wait cycles", wc, 130);
        check_output("miss burst count", rd_bursts, 1);
        check_output("miss burst addr", last_rd_addr, 32'h1000);

        vecs[0] = '{32'h1004, init_word(32'h1004), 1};
        vecs[1] = '{32'h1008, init_word(32'h1008), 1};
        vecs[2] = '{32'h1100, init_word(32'h1100), 1};
        vecs[3] = '{32'h11FC, init_word(32'h11FC), 1};
        vecs[4] = '{32'h1000, init_word(32'h1000), 1};
        vecs[5] = '{32'h1083, init_word(32'h1080), 1};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1, 0, vecs[i].addr, 0, d, wc);
            check_output($sformatf("hit data %h", vecs[i].addr), d, vecs[i].exp_data);
            check_output($sformatf("hit wait %h", vecs[i].addr), wc, vecs[i].exp_wait);
        end
        check_output("hits issue no burst", rd_bursts, 1);

        // Full sequential write sector under random stalls.
        stall_en = 1'b1;
        bad = 0;
        for (int i = 0; i < BW - 1; i++) begin
            apply_stimulus(0, 1, 32'h2000 + 32'(4 * i), wdat(i), d, wc);
            if (wc != 1) bad++;
        end
        check_output("gather writes wait 1", bad, 0);
        check_output("no burst before last write", wr_bursts, 0);
        apply_stimulus(0, 1, 32'h21FC, wdat(BW - 1), d, wc);
        check_output("flush busy long enough", (wc >= 129) ? 1 : 0, 1);
        stall_en = 1'b0;
        repeat (5) @(negedge clk_sys);
        check_output("write burst count", wr_bursts, 1);
        check_output("write beats total", wr_beats_total, BW);
        check_output("write burst addr", last_wr_addr, 32'h2000);
        check_output("write addr stable", wr_addr_err, 0);
        bad = 0;
        for (int i = 0; i < BW; i++) if (wr_capt[i] !== wdat(i)) bad++;
        check_output("write burst data order", bad, 0);
        check_output("mem_write idle", mem_write, 0);

        // Writes invalidated the read buffer; inv does the same.
        apply_stimulus(1, 0, 32'h1000, 0, d, wc);
        check_output("refill after write data", d, init_word(32'h1000));
        check_output("refill after write burst", rd_bursts, 2);
        apply_stimulus(1, 0, 32'h1004, 0, d, wc);
        check_output("hit before inv", rd_bursts, 2);
        @(negedge clk_sys); inv = 1'b1;
        @(negedge clk_sys); inv = 1'b0;
        apply_stimulus(1, 0, 32'h1004, 0, d, wc);
        check_output("refill after inv data", d, init_word(32'h1004));
        check_output("refill after inv burst", rd_bursts, 3);

        apply_stimulus(1, 0, 32'h2010, 0, d, wc);
        check_output("read back written", d, wdat(4));
        check_output("read back burst", rd_bursts, 4);

        // Simultaneous read and write: read wins, write is dropped.
        apply_stimulus(1, 1, 32'h2014, 32'hDEAD_BEEF, d, wc);
        check_output("rd+wr read data", d, wdat(5));
        check_output("rd+wr wait", wc, 1);
        apply_stimulus(1, 0, 32'h2014, 0, d, wc);
        check_output("rd+wr buffer unchanged", d, wdat(5));
        check_output("rd+wr no write burst", wr_bursts, 1);

        // Read request while busy is ignored.
        rb0 = rd_bursts;
        @(negedge clk_sys); dma_rd = 1'b1; dma_addr = 32'h3000;
        @(negedge clk_sys); dma_rd = 1'b0;
        repeat (5) @(negedge clk_sys);
        dma_rd = 1'b1; dma_addr = 32'h4000;
        @(negedge clk_sys); dma_rd = 1'b0;
        wait_idle(wc);
        check_output("busy read data", dma_din, init_word(32'h3000));
        repeat (20) @(negedge clk_sys);
        check_output("busy read single burst", rd_bursts, rb0 + 1);
        check_output("busy read addr", last_rd_addr, 32'h3000);
        check_output("busy read idle", ioctl_wait, 0);

        // Partial sector write: no flush.
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 32'h5000 + 32'(4 * i), wdat(i), d, wc);
        repeat (10) @(negedge clk_sys);
        check_output("partial write no burst", wr_bursts, 1);

        // Reset in the middle of a fill.
        rb0 = rd_bursts;
        @(negedge clk_sys); dma_rd = 1'b1; dma_addr = 32'h6000;
        @(negedge clk_sys); dma_rd = 1'b0;
        wc = 0;
        while (!(rd_bursts == rb0 + 1 && rd_sent >= 40) && wc < 500) begin
            @(posedge clk_sys);
            wc++;
        end
        check_output("reached beat 40", (wc < 500) ? 1 : 0, 1);
        @(negedge clk_sys); reset = 1'b1;
        @(negedge clk_sys);
        check_output("mid reset ioctl_wait", ioctl_wait, 0);
        check_output("mid reset mem_read", mem_read, 0);
        reset = 1'b0;
        repeat (200) @(negedge clk_sys);
        apply_stimulus(1, 0, 32'h6008, 0, d, wc);
        check_output("post reset refill data", d, init_word(32'h6008));
        check_output("post reset refill burst", rd_bursts, rb0 + 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
